// File: rtl/rift2_wb_pkg.sv
// Shared types, default constants and helpers for the rift2 Wishbone bridge.
package rift2_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_ACK  = 2'd3
   } wb_state_e;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } wb_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } wb_rsp_t;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
   localparam logic [31:0] DEF_ADDR_MASK = 32'hFF00_0000;
   localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;
   localparam logic [31:0] DEF_CSR_ADDR  = 32'h3FFF_FFF0;
   localparam int unsigned DEF_TIMEOUT   = 256;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rift2_wb_timeout.sv
// Loadable up-counter with clear/enable; expired_o flags cnt == limit_i and the count holds there.
module rift2_wb_timeout
   import rift2_wb_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [CNT_W-1:0] ld_val_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired_o = (cnt_q == limit_i);
   assign cnt_o     = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (ld_i) begin
         cnt_d = ld_val_i;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rift2_wb_bridge.sv
// Wishbone-classic slave turning single-beat cycles into valid/ready requests toward the Rift2 core.
// Define RIFT2_WB_BRIDGE_STATS_EN to add the transaction/timeout statistics CSR.
module rift2_wb_bridge
   import rift2_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
   parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA,
   parameter logic [31:0] CSR_ADDR  = DEF_CSR_ADDR
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_write,
   output logic [31:0] req_addr,
   output logic [31:0] req_wdata,
   output logic [3:0]  req_wstrb,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_rdata,
   input  logic        rsp_err,
   output logic        err_irq
);

   // The timer expires on the WAIT cycle in which the count would reach TIMEOUT-1.
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT - 32'd2);

   wb_state_e   state_q;
   wb_req_t     req_q;
   logic        req_valid_q;
   logic        ack_q;
   logic        irq_q;
   logic [31:0] dat_q;

   logic        start;
   logic        win_hit;
   logic        csr_hit;
   logic [31:0] csr_rdata;
   wb_rsp_t     rsp;
   logic        to_clr;
   logic        to_en;
   logic        to_expired;
   logic        to_evt;
   logic [15:0] unused_to_cnt;

   assign start   = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign win_hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
   assign rsp     = '{rdata: rsp_rdata, err: rsp_err};
   assign to_clr  = (state_q == ST_REQ) & req_ready;
   assign to_en   = (state_q == ST_WAIT);
   assign to_evt  = to_en & ~rsp_valid & to_expired;

   rift2_wb_timeout #(
      .CNT_W (16)
   ) u_timeout (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .clr_i     (to_clr),
      .ld_i      (1'b0),
      .ld_val_i  (16'd0),
      .en_i      (to_en),
      .limit_i   (TO_LIMIT),
      .cnt_o     (unused_to_cnt),
      .expired_o (to_expired)
   );

`ifdef RIFT2_WB_BRIDGE_STATS_EN
   logic [15:0] txn_cnt_q;
   logic [15:0] to_cnt_q;
   logic        csr_clr;

   assign csr_hit   = (wbs_adr_i == CSR_ADDR);
   assign csr_rdata = {to_cnt_q, txn_cnt_q};
   assign csr_clr   = (state_q == ST_IDLE) & start & csr_hit & wbs_we_i;

   // Clearing happens at decode, so the clearing write's own ack is the first one counted.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         txn_cnt_q <= '0;
         to_cnt_q  <= '0;
      end else if (csr_clr) begin
         txn_cnt_q <= '0;
         to_cnt_q  <= '0;
      end else begin
         if (ack_q) begin
            txn_cnt_q <= sat_inc16(txn_cnt_q);
         end
         if (to_evt) begin
            to_cnt_q <= sat_inc16(to_cnt_q);
         end
      end
   end
`else
   logic unused_csr;

   assign csr_hit    = 1'b0;
   assign csr_rdata  = '0;
   assign unused_csr = ^{CSR_ADDR, to_evt};
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         req_valid_q <= 1'b0;
         ack_q       <= 1'b0;
         irq_q       <= 1'b0;
         dat_q       <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (csr_hit) begin
                     state_q <= ST_ACK;
                     ack_q   <= 1'b1;
                     if (wbs_we_i) begin
                        irq_q <= 1'b0;
                     end else begin
                        dat_q <= csr_rdata;
                     end
                  end else if (win_hit) begin
                     state_q     <= ST_REQ;
                     req_valid_q <= 1'b1;
                     req_q       <= '{write: wbs_we_i,
                                      addr:  wbs_adr_i & ~ADDR_MASK,
                                      wdata: wbs_dat_i,
                                      wstrb: wbs_sel_i};
                  end else begin
                     // Missed writes are dropped; only reads get the error pattern.
                     state_q <= ST_ACK;
                     ack_q   <= 1'b1;
                     irq_q   <= 1'b1;
                     if (!wbs_we_i) begin
                        dat_q <= ERR_DATA;
                     end
                  end
               end
            end
            ST_REQ: begin
               // The core cannot cancel, so a master abort here still completes.
               if (req_ready) begin
                  req_valid_q <= 1'b0;
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (rsp_valid) begin
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
                  dat_q   <= rsp.err ? ERR_DATA : rsp.rdata;
                  if (rsp.err) begin
                     irq_q <= 1'b1;
                  end
               end else if (to_expired) begin
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
                  dat_q   <= ERR_DATA;
                  irq_q   <= 1'b1;
               end
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign req_valid = req_valid_q;
   assign req_write = req_q.write;
   assign req_addr  = req_q.addr;
   assign req_wdata = req_q.wdata;
   assign req_wstrb = req_q.wstrb;
   assign err_irq   = irq_q;

endmodule

// File: tb/tb_rift2_wb_bridge.sv
// Bench for rift2_wb_bridge: table vectors, hand-written corner sequences and randomized
// transactions checked against a transaction-level model of the bridge.
module tb_rift2_wb_bridge;

   localparam int unsigned T   = 8;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   localparam logic [31:0] CSR = 32'h3FFF_FFF0;
`ifdef RIFT2_WB_BRIDGE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, we_i;
   logic [3:0]  sel_i;
   logic [31:0] adr_i, dat_i;
   logic        ack;
   logic [31:0] dat_o;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        err_irq;

   int checks = 0;
   int errors = 0;

   // Observations from the last transaction
   int          o_lat, o_hs, o_vcyc, o_unstable;
   logic [31:0] o_dat;
   logic        o_irq, o_ack_after;
   logic [68:0] o_req;

   // Model state
   logic [31:0] m_dat;
   logic        m_irq;
   logic [15:0] m_txn, m_to;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          rdy;
      int          rsp;
      logic        err;
      logic [31:0] rdata;
      int          e_lat;
      logic [31:0] e_dat;
      logic        e_irq;
      int          e_hs;
      logic [31:0] e_raddr;
   } vec_t;

   vec_t tbl [6];

   rift2_wb_bridge #(.TIMEOUT(T)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we_i),
      .wbs_sel_i (sel_i),
      .wbs_adr_i (adr_i),
      .wbs_dat_i (dat_i),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .err_irq   (err_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc = 0; stb = 0; we_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
      req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_dat = '0; m_irq = 1'b0; m_txn = '0; m_to = '0;
   endtask

   // Acts as Wishbone master and as the core; must be called at a negedge.
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int rdy_dly, input int rsp_dly,
                       input logic err, input logic [31:0] rdata, input logic hs_junk);
      int          hs_k;
      logic        done;
      logic [68:0] first, cur;
      o_lat = -1; o_hs = 0; o_vcyc = 0; o_unstable = 0; hs_k = -100; done = 1'b0;
      first = '0;
      cyc = 1; stb = 1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
      req_ready = 0; rsp_valid = 0;
      for (int k = 1; k <= 200 && !done; k++) begin
         @(negedge clk);
         req_ready = 0; rsp_valid = 0; rsp_err = 0;
         if (ack) begin
            o_lat = k; o_dat = dat_o; o_irq = err_irq; done = 1'b1;
            cyc = 0; stb = 0;
         end else begin
            if (req_valid) begin
               cur = {req_write, req_addr, req_wdata, req_wstrb};
               if (o_vcyc == 0) first = cur;
               else if (cur !== first) o_unstable++;
               o_vcyc++;
               if (o_vcyc > rdy_dly) begin
                  req_ready = 1; o_hs++; hs_k = k; o_req = cur;
                  if (hs_junk) begin
                     rsp_valid = 1; rsp_rdata = 32'h0BAD_0BAD; rsp_err = 1;
                  end
               end
            end
            if (rsp_dly >= 0 && k == hs_k + 1 + rsp_dly) begin
               rsp_valid = 1; rsp_rdata = rdata; rsp_err = err;
            end
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL ack_wait actual=none required=ack within 200 cycles");
         cyc = 0; stb = 0;
      end
      @(negedge clk);
      req_ready = 0; rsp_valid = 0; rsp_err = 0;
      o_ack_after = ack;
   endtask

   // Transaction-level expectation from the bridge's rules; updates the model state.
   task automatic model(input logic we, input logic [31:0] adr, input int rdy, input int rsp,
                        input logic err, input logic [31:0] rdata,
                        output int e_lat, output int e_hs);
      logic hit;
      hit  = ((adr & 32'hFF00_0000) == 32'h3000_0000);
      e_hs = 0;
      if (STATS && adr == CSR) begin
         e_lat = 1;
         if (we) begin
            m_txn = '0; m_to = '0; m_irq = 1'b0;
         end else begin
            m_dat = {m_to, m_txn};
         end
      end else if (!hit) begin
         e_lat = 1; m_irq = 1'b1;
         if (!we) m_dat = ERR;
      end else begin
         e_hs = 1;
         if (rsp >= 0 && rsp <= int'(T) - 2) begin
            e_lat = rdy + 3 + rsp;
            m_dat = err ? ERR : rdata;
            if (err) m_irq = 1'b1;
         end else begin
            e_lat = 1 + rdy + int'(T);
            m_dat = ERR; m_irq = 1'b1;
            if (m_to != 16'hFFFF) m_to++;
         end
      end
      if (m_txn != 16'hFFFF) m_txn++;
   endtask

   initial begin
      int          e_lat, e_hs;
      logic [31:0] r32, adr;
      logic        we, err, junk;
      int          rdy, rsp;

      tbl[0] = '{1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 0, 1'b0, 32'h1234_5678,
                 3, 32'h1234_5678, 1'b0, 1, 32'h0000_0010};
      tbl[1] = '{1'b1, 32'h3000_0004, 32'hA5A5_A5A5, 4'b0011, 5, 0, 1'b0, 32'h0,
                 8, 32'h0000_0000, 1'b0, 1, 32'h0000_0004};
      tbl[2] = '{1'b0, 32'h2000_0000, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0,
                 1, 32'hDEAD_BEEF, 1'b1, 0, 32'h0};
      tbl[3] = '{1'b0, 32'h3000_0100, 32'h0, 4'hF, 2, 3, 1'b1, 32'h1111_1111,
                 8, 32'hDEAD_BEEF, 1'b1, 1, 32'h0000_0100};
      tbl[4] = '{1'b0, 32'h30AB_CDEC, 32'h0, 4'hF, 0, -1, 1'b0, 32'h0,
                 9, 32'hDEAD_BEEF, 1'b1, 1, 32'h00AB_CDEC};
      tbl[5] = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 6, 1'b0, 32'hCAFE_F00D,
                 10, 32'hCAFE_F00D, 1'b1, 1, 32'h0000_0020};

      do_reset();
      chk("rst_ack", 69'(ack), 69'(0));
      chk("rst_dat", 69'(dat_o), 69'(0));
      chk("rst_req_valid", 69'(req_valid), 69'(0));
      chk("rst_req", {req_write, req_addr, req_wdata, req_wstrb}, 69'(0));
      chk("rst_irq", 69'(err_irq), 69'(0));

      // Table vectors
      for (int i = 0; i < 6; i++) begin
         xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].rdy, tbl[i].rsp,
              tbl[i].err, tbl[i].rdata, 1'b0);
         chk($sformatf("tbl%0d_lat", i), 69'(o_lat), 69'(tbl[i].e_lat));
         chk($sformatf("tbl%0d_dat", i), 69'(o_dat), 69'(tbl[i].e_dat));
         chk($sformatf("tbl%0d_irq", i), 69'(o_irq), 69'(tbl[i].e_irq));
         chk($sformatf("tbl%0d_hs", i), 69'(o_hs), 69'(tbl[i].e_hs));
         chk($sformatf("tbl%0d_ack1", i), 69'(o_ack_after), 69'(0));
         if (tbl[i].e_hs != 0) begin
            chk($sformatf("tbl%0d_req", i), o_req,
                {tbl[i].we, tbl[i].e_raddr, tbl[i].dat, tbl[i].sel});
            chk($sformatf("tbl%0d_stable", i), 69'(o_unstable), 69'(0));
         end else begin
            chk($sformatf("tbl%0d_novalid", i), 69'(o_vcyc), 69'(0));
         end
      end

      // Timeout, then a late response in IDLE must be ignored
      do_reset();
      xfer(1'b0, 32'h3000_0040, 32'h0, 4'hF, 0, -1, 1'b0, 32'h0, 1'b0);
      chk("to_lat", 69'(o_lat), 69'(1 + T));
      chk("to_dat", 69'(o_dat), 69'(ERR));
      chk("to_irq", 69'(o_irq), 69'(1));
      rsp_valid = 1; rsp_rdata = 32'h55AA_55AA; rsp_err = 0;
      @(negedge clk);
      rsp_valid = 0;
      chk("late_ack", 69'(ack), 69'(0));
      chk("late_valid", 69'(req_valid), 69'(0));
      @(negedge clk);
      chk("late_dat", 69'(dat_o), 69'(ERR));
      chk("late_ack2", 69'(ack), 69'(0));
      xfer(1'b0, 32'h3000_0044, 32'h0, 4'hF, 0, 0, 1'b0, 32'h7777_0001, 1'b1);
      chk("after_late_lat", 69'(o_lat), 69'(3));
      chk("after_late_dat", 69'(o_dat), 69'(32'h7777_0001));

      // Asynchronous reset while a request is stalled in REQ
      do_reset();
      cyc = 1; stb = 1; we_i = 0; adr_i = 32'h3000_0080; sel_i = 4'hF; req_ready = 0;
      @(negedge clk);
      chk("mid_req_valid", 69'(req_valid), 69'(1));
      #2 rst = 1'b1;
      #1;
      chk("async_valid", 69'(req_valid), 69'(0));
      chk("async_ack", 69'(ack), 69'(0));
      cyc = 0; stb = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 69'(req_valid), 69'(0));
      xfer(1'b0, 32'h3000_0084, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0101_0202, 1'b0);
      chk("post_rst_lat", 69'(o_lat), 69'(3));
      chk("post_rst_dat", 69'(o_dat), 69'(32'h0101_0202));

`ifdef RIFT2_WB_BRIDGE_STATS_EN
      do_reset();
      for (int i = 0; i < 3; i++)
         xfer(1'b0, 32'h3000_0100 + 32'(i * 4), 32'h0, 4'hF, 0, 0, 1'b0, 32'(i), 1'b0);
      xfer(1'b0, 32'h3000_0200, 32'h0, 4'hF, 0, -1, 1'b0, 32'h0, 1'b0);
      xfer(1'b0, CSR, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
      chk("csr_rd_lat", 69'(o_lat), 69'(1));
      chk("csr_rd_dat", 69'(o_dat), 69'(32'h0001_0004));
      chk("csr_rd_hs", 69'(o_hs), 69'(0));
      xfer(1'b1, CSR, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
      chk("csr_wr_irq", 69'(o_irq), 69'(0));
      xfer(1'b0, CSR, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
      chk("csr_clr_dat", 69'(o_dat), 69'(32'h0000_0001));
      do_reset();
      xfer(1'b0, 32'h3000_0300, 32'h0, 4'hF, 0, int'(T) - 2, 1'b0, 32'h4242_4242, 1'b0);
      chk("coll_dat", 69'(o_dat), 69'(32'h4242_4242));
      xfer(1'b0, CSR, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
      chk("coll_to_cnt", 69'(o_dat), 69'(32'h0000_0001));
`else
      do_reset();
      xfer(1'b0, CSR, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b0);
      chk("csr_miss_lat", 69'(o_lat), 69'(1));
      chk("csr_miss_dat", 69'(o_dat), 69'(ERR));
      chk("csr_miss_hs", 69'(o_hs), 69'(0));
`endif

      // Randomized transactions against the model
      do_reset();
      for (int i = 0; i < 150; i++) begin
         r32 = $urandom();
         if ($urandom_range(0, 3) != 0) begin
            adr = {8'h30, r32[23:0]};
         end else begin
            adr = r32;
            while (adr[31:24] == 8'h30 || adr[31:24] == 8'h3F) begin
               r32 = $urandom();
               adr = r32;
            end
         end
         we   = 1'($urandom_range(0, 1));
         rdy  = int'($urandom_range(0, 4));
         rsp  = int'($urandom_range(0, T + 1)) - 1;
         err  = ($urandom_range(0, 7) == 0);
         junk = ($urandom_range(0, 3) == 0);
         r32  = $urandom();
         dat_i = 0;
         model(we, adr, rdy, rsp, err, r32, e_lat, e_hs);
         begin
            logic [31:0] wd;
            logic [3:0]  sl;
            wd = $urandom();
            sl = 4'($urandom_range(0, 15));
            xfer(we, adr, wd, sl, rdy, rsp, err, r32, junk);
            chk("rnd_lat", 69'(o_lat), 69'(e_lat));
            chk("rnd_dat", 69'(o_dat), 69'(m_dat));
            chk("rnd_irq", 69'(o_irq), 69'(m_irq));
            chk("rnd_hs", 69'(o_hs), 69'(e_hs));
            chk("rnd_ack1", 69'(o_ack_after), 69'(0));
            chk("rnd_vcyc", 69'(o_vcyc), 69'((e_hs != 0) ? rdy + 1 : 0));
            if (e_hs != 0) begin
               chk("rnd_req", o_req, {we, adr & 32'h00FF_FFFF, wd, sl});
               chk("rnd_stable", 69'(o_unstable), 69'(0));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
